tcdm_bank_responder: RTL and testbench

- Bank-side end of the tile TCDM request/response protocol.
- Accepts `tcdm_slave_req_t` requests, drives one single-port SRAM bank with 1-cycle read latency, and executes loads, stores, AMOs and LR/SC.
- Returns `tcdm_slave_resp_t` responses with the payload metadata and `ini_addr` echoed.
- One instance per bank inside the tile, between the tile crossbar and the bank macro.

---
 rtl/tcdm_bank_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_tcdm_bank_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// Bank-side TCDM responder: accepts tile crossbar requests, drives a single-port
// SRAM bank (1-cycle read latency) and returns in-order responses for loads,
// AMOs and LR/SC. The request/response types live in mempool_pkg below.

package mempool_pkg;

    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
    endfunction

    localparam int unsigned NumCoresPerTile  = 4;
    localparam int unsigned NumBanksPerTile  = 16;
    localparam int unsigned TCDMAddrMemWidth = 10;
    localparam int unsigned MetaIdWidth      = 4;
    localparam int unsigned IniAddrWidth     = 4;
    localparam int unsigned CoreIdWidth      = idx_width(NumCoresPerTile);
    localparam int unsigned TCDMAddrWidth    = TCDMAddrMemWidth + idx_width(NumBanksPerTile);

    typedef logic [31:0]               data_t;
    typedef logic [3:0]                strb_t;
    typedef logic [3:0]                amo_t;
    typedef logic [MetaIdWidth-1:0]    meta_id_t;
    typedef logic [CoreIdWidth-1:0]    core_id_t;
    typedef logic [IniAddrWidth-1:0]   ini_addr_t;
    typedef logic [TCDMAddrWidth-1:0]  tcdm_addr_t;

    localparam amo_t AmoNone = 4'h0;
    localparam amo_t AmoSwap = 4'h1;
    localparam amo_t AmoAdd  = 4'h2;
    localparam amo_t AmoAnd  = 4'h3;
    localparam amo_t AmoOr   = 4'h4;
    localparam amo_t AmoXor  = 4'h5;
    localparam amo_t AmoMax  = 4'h6;
    localparam amo_t AmoMaxu = 4'h7;
    localparam amo_t AmoMin  = 4'h8;
    localparam amo_t AmoMinu = 4'h9;
    localparam amo_t AmoLr   = 4'hA;
    localparam amo_t AmoSc   = 4'hB;

    typedef struct packed {
        meta_id_t meta_id;
        core_id_t core_id;
        amo_t     amo;
        data_t    data;
    } tcdm_payload_t;

    typedef struct packed {
        tcdm_payload_t wdata;
        logic          wen;
        strb_t         be;
        tcdm_addr_t    tgt_addr;
        ini_addr_t     ini_addr;
    } tcdm_slave_req_t;

    typedef struct packed {
        tcdm_payload_t rdata;
        ini_addr_t     ini_addr;
    } tcdm_slave_resp_t;

endpackage

module tcdm_bank_responder #(
    parameter int unsigned RespDepth       = 2,
    parameter int unsigned NumBanksPerTile = mempool_pkg::NumBanksPerTile,
    parameter int unsigned BankAddrWidth   = mempool_pkg::TCDMAddrMemWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  mempool_pkg::tcdm_slave_req_t  req_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output mempool_pkg::tcdm_slave_resp_t resp_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [BankAddrWidth-1:0]      mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    output logic [3:0]                    mem_be_o,
    input  logic [31:0]                   mem_rdata_i
);

    localparam int unsigned BankSelWidth = mempool_pkg::idx_width(NumBanksPerTile);
    localparam int unsigned PtrWidth     = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntWidth     = $clog2(RespDepth + 1);
    localparam int unsigned UsedWidth    = CntWidth + 1;

    typedef enum logic {
        IDLE,
        AMO_WB
    } state_e;

    state_e state;

    // Request decode
    logic                     is_amo;
    logic                     is_lr;
    logic                     is_sc;
    logic                     is_store;
    logic                     accept;
    logic                     sc_success;
    logic [BankAddrWidth-1:0] row;
    logic                     unused_bank_sel;

    // Pending response for a read or SC issued in the previous cycle
    logic                          pend_valid;
    logic                          pend_sc;
    logic                          pend_sc_fail;
    mempool_pkg::tcdm_payload_t    pend_payload;
    mempool_pkg::ini_addr_t        pend_ini;
    logic [BankAddrWidth-1:0]      pend_row;

    // Reservation
    logic                          resv_valid;
    logic [BankAddrWidth-1:0]      resv_row;
    mempool_pkg::ini_addr_t        resv_ini;
    mempool_pkg::core_id_t         resv_core;

    // Response FIFO
    mempool_pkg::tcdm_slave_resp_t fifo_q [RespDepth];
    logic [PtrWidth-1:0]           rd_ptr;
    logic [PtrWidth-1:0]           wr_ptr;
    logic [CntWidth-1:0]           count;
    logic                          fifo_empty;
    logic                          push_valid;
    mempool_pkg::tcdm_slave_resp_t push_data;
    logic                          pop;
    logic                          do_write;
    logic                          do_read;
    logic [UsedWidth-1:0]          used;

    function automatic logic [31:0] amo_result(input mempool_pkg::amo_t op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
        logic [31:0] res;
        res = old_val;
        case (op)
            mempool_pkg::AmoSwap: res = operand;
            mempool_pkg::AmoAdd:  res = old_val + operand;
            mempool_pkg::AmoAnd:  res = old_val & operand;
            mempool_pkg::AmoOr:   res = old_val | operand;
            mempool_pkg::AmoXor:  res = old_val ^ operand;
            mempool_pkg::AmoMax:  res = ($signed(old_val) > $signed(operand)) ? old_val : operand;
            mempool_pkg::AmoMaxu: res = (old_val > operand) ? old_val : operand;
            mempool_pkg::AmoMin:  res = ($signed(old_val) < $signed(operand)) ? old_val : operand;
            mempool_pkg::AmoMinu: res = (old_val < operand) ? old_val : operand;
            default:              res = old_val;
        endcase
        return res;
    endfunction

    // Classify the incoming request and evaluate the SC reservation match
    always_comb begin
        row             = req_i.tgt_addr[BankSelWidth +: BankAddrWidth];
        unused_bank_sel = ^req_i.tgt_addr[BankSelWidth-1:0];
        is_amo          = (req_i.wdata.amo >= mempool_pkg::AmoSwap) &&
                          (req_i.wdata.amo <= mempool_pkg::AmoMinu);
        is_lr           = (req_i.wdata.amo == mempool_pkg::AmoLr);
        is_sc           = (req_i.wdata.amo == mempool_pkg::AmoSc);
        is_store        = !is_amo && !is_lr && !is_sc && req_i.wen;
        accept          = req_valid_i && req_ready_o;
        sc_success      = resv_valid && (resv_row == row) &&
                          (resv_ini == req_i.ini_addr) &&
                          (resv_core == req_i.wdata.core_id);
    end

    // Response push, fall-through FIFO head selection and request credit
    always_comb begin
        push_valid          = pend_valid && !rst_i;
        push_data.rdata     = pend_payload;
        push_data.rdata.data = pend_sc ? {31'b0, pend_sc_fail} : mem_rdata_i;
        push_data.ini_addr  = pend_ini;
        fifo_empty          = (count == '0);
        resp_valid_o        = !rst_i && (!fifo_empty || push_valid);
        resp_o              = fifo_empty ? push_data : fifo_q[rd_ptr];
        pop                 = resp_valid_o && resp_ready_i;
        do_write            = push_valid && !(fifo_empty && pop);
        do_read             = pop && !fifo_empty;
        // Credit counts the response landing this cycle and releases one being popped.
        used                = UsedWidth'(count) + UsedWidth'(push_valid) - UsedWidth'(pop);
        req_ready_o         = !rst_i && (state == IDLE) && (used < UsedWidth'(RespDepth));
    end

    // SRAM port: AMO writeback in AMO_WB, otherwise the accepted request
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (!rst_i) begin
            if (state == AMO_WB) begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = pend_row;
                mem_wdata_o = amo_result(pend_payload.amo, mem_rdata_i, pend_payload.data);
                mem_be_o    = '1;
            end else if (accept) begin
                mem_addr_o  = row;
                mem_wdata_o = req_i.wdata.data;
                mem_be_o    = req_i.be;
                if (is_sc) begin
                    mem_req_o = sc_success;
                    mem_we_o  = sc_success;
                end else begin
                    mem_req_o = 1'b1;
                    mem_we_o  = is_store;
                end
            end
        end
    end

    // Control FSM: latch request metadata and sequence AMO read/writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            pend_valid   <= 1'b0;
            pend_sc      <= 1'b0;
            pend_sc_fail <= 1'b0;
            pend_payload <= '0;
            pend_ini     <= '0;
            pend_row     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pend_valid <= accept && !is_store;
                    if (accept) begin
                        pend_sc      <= is_sc;
                        pend_sc_fail <= !sc_success;
                        pend_payload <= req_i.wdata;
                        pend_ini     <= req_i.ini_addr;
                        pend_row     <= row;
                        if (is_amo) begin
                            state <= AMO_WB;
                        end
                    end
                end
                AMO_WB: begin
                    pend_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Reservation tracking for LR/SC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resv_valid <= 1'b0;
            resv_row   <= '0;
            resv_ini   <= '0;
            resv_core  <= '0;
        end else if (accept) begin
            if (is_lr) begin
                resv_valid <= 1'b1;
                resv_row   <= row;
                resv_ini   <= req_i.ini_addr;
                resv_core  <= req_i.wdata.core_id;
            end else if (is_sc) begin
                resv_valid <= 1'b0;
            end else if ((is_store || is_amo) && (row == resv_row)) begin
                resv_valid <= 1'b0;
            end
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= (wr_ptr == PtrWidth'(RespDepth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (do_read) begin
                rd_ptr <= (rd_ptr == PtrWidth'(RespDepth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end
            count <= count + CntWidth'(do_write) - CntWidth'(do_read);
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            fifo_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed self-checking bench for tcdm_bank_responder with a behavioural SRAM.

module tb_tcdm_bank_responder;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          req_valid;
    logic                          req_ready;
    mempool_pkg::tcdm_slave_req_t  req;
    logic                          resp_valid;
    logic                          resp_ready;
    mempool_pkg::tcdm_slave_resp_t resp;
    logic                          mem_req;
    logic                          mem_we;
    logic [9:0]                    mem_addr;
    logic [31:0]                   mem_wdata;
    logic [3:0]                    mem_be;
    logic [31:0]                   mem_rdata;

    logic [31:0] sram [1024];

    int n_tests = 0;
    int n_fail  = 0;

    tcdm_bank_responder #(
        .RespDepth       (2),
        .NumBanksPerTile (16),
        .BankAddrWidth   (10)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_i        (req),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_o       (resp),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with byte enables and 1-cycle read latency
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, return at #1 into the cycle after acceptance
    task automatic do_req(input logic [3:0] amo, input logic wen, input logic [3:0] be,
                          input logic [9:0] row, input logic [31:0] data,
                          input logic [3:0] ini, input logic [1:0] core, input logic [3:0] meta);
        int unsigned waits;
        waits              = 0;
        req.wdata.meta_id  = meta;
        req.wdata.core_id  = core;
        req.wdata.amo      = amo;
        req.wdata.data     = data;
        req.wen            = wen;
        req.be             = be;
        req.tgt_addr       = {row, 4'h3};
        req.ini_addr       = ini;
        req_valid          = 1'b1;
        #1;
        while (!req_ready && waits < 20) begin
            @(posedge clk);
            #2;
            waits++;
        end
        check("accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] data,
                               input logic [3:0] ini, input logic [3:0] meta);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_data"}, resp.rdata.data, data);
        check({tag, "_ini"}, 32'(resp.ini_addr), 32'(ini));
        check({tag, "_meta"}, 32'(resp.rdata.meta_id), 32'(meta));
    endtask

    task automatic load(input string tag, input logic [9:0] row, input logic [31:0] exp,
                        input logic [3:0] ini, input logic [3:0] meta);
        do_req(4'h0, 1'b0, 4'hF, row, 32'h0, ini, 2'd0, meta);
        expect_resp(tag, exp, ini, meta);
        step();
    endtask

    task automatic store(input logic [9:0] row, input logic [31:0] data, input logic [3:0] be,
                         input logic [3:0] ini, input logic [1:0] core);
        do_req(4'h0, 1'b1, be, row, data, ini, core, 4'h0);
        check("store_noresp", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req        = '0;
        resp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        step();

        // Store / load / partial store
        store(10'd5, 32'hDEADBEEF, 4'hF, 4'd1, 2'd0);
        load("ld5", 10'd5, 32'hDEADBEEF, 4'd2, 4'd5);
        check("ld5_single", 32'(resp_valid), 32'd0);
        store(10'd5, 32'h0000AA00, 4'b0010, 4'd1, 2'd0);
        load("ld5_be", 10'd5, 32'hDEADAAEF, 4'd6, 4'd7);

        // AMOADD wraps, busy for one cycle, new value visible at t+2
        store(10'd3, 32'hFFFFFFFF, 4'hF, 4'd1, 2'd0);
        do_req(mempool_pkg::AmoAdd, 1'b0, 4'h1, 10'd3, 32'd1, 4'd4, 2'd2, 4'd9);
        check("amo_busy", 32'(req_ready), 32'd0);
        expect_resp("amoadd", 32'hFFFFFFFF, 4'd4, 4'd9);
        step();
        check("amo_ready_again", 32'(req_ready), 32'd1);
        load("ld3", 10'd3, 32'h00000000, 4'd1, 4'd1);

        // Signed MIN / MAX against the most negative value
        store(10'd4, 32'h80000000, 4'hF, 4'd1, 2'd0);
        do_req(mempool_pkg::AmoMin, 1'b0, 4'hF, 10'd4, 32'd5, 4'd3, 2'd0, 4'd2);
        expect_resp("amomin", 32'h80000000, 4'd3, 4'd2);
        step();
        load("ld4_min", 10'd4, 32'h80000000, 4'd1, 4'd3);
        do_req(mempool_pkg::AmoMax, 1'b0, 4'hF, 10'd4, 32'd5, 4'd3, 2'd0, 4'd4);
        expect_resp("amomax", 32'h80000000, 4'd3, 4'd4);
        step();
        load("ld4_max", 10'd4, 32'h00000005, 4'd1, 4'd5);

        // LR/SC
        store(10'd7, 32'h12345678, 4'hF, 4'd1, 2'd0);
        do_req(mempool_pkg::AmoLr, 1'b0, 4'hF, 10'd7, 32'h0, 4'd2, 2'd1, 4'd1);
        expect_resp("lr", 32'h12345678, 4'd2, 4'd1);
        step();
        do_req(mempool_pkg::AmoSc, 1'b1, 4'hF, 10'd7, 32'hCAFEF00D, 4'd2, 2'd1, 4'd2);
        expect_resp("sc_ok", 32'd0, 4'd2, 4'd2);
        check("sc_amo_echo", 32'(resp.rdata.amo), 32'hB);
        step();
        load("ld7_sc", 10'd7, 32'hCAFEF00D, 4'd1, 4'd3);
        do_req(mempool_pkg::AmoSc, 1'b1, 4'hF, 10'd7, 32'h11111111, 4'd2, 2'd1, 4'd4);
        expect_resp("sc_again", 32'd1, 4'd2, 4'd4);
        step();
        load("ld7_nowr", 10'd7, 32'hCAFEF00D, 4'd1, 4'd5);

        do_req(mempool_pkg::AmoLr, 1'b0, 4'hF, 10'd7, 32'h0, 4'd2, 2'd1, 4'd6);
        step();
        store(10'd7, 32'h22222222, 4'hF, 4'd3, 2'd0);
        do_req(mempool_pkg::AmoSc, 1'b1, 4'hF, 10'd7, 32'h33333333, 4'd2, 2'd1, 4'd7);
        expect_resp("sc_after_st", 32'd1, 4'd2, 4'd7);
        step();
        load("ld7_st", 10'd7, 32'h22222222, 4'd1, 4'd8);

        do_req(mempool_pkg::AmoLr, 1'b0, 4'hF, 10'd7, 32'h0, 4'd2, 2'd1, 4'd9);
        step();
        do_req(mempool_pkg::AmoSc, 1'b1, 4'hF, 10'd7, 32'h44444444, 4'd3, 2'd1, 4'd10);
        expect_resp("sc_other", 32'd1, 4'd3, 4'd10);
        step();

        do_req(mempool_pkg::AmoLr, 1'b0, 4'hF, 10'd7, 32'h0, 4'd2, 2'd1, 4'd11);
        step();
        load("ld7_mid", 10'd7, 32'h22222222, 4'd3, 4'd12);
        do_req(mempool_pkg::AmoSc, 1'b1, 4'hF, 10'd7, 32'h55555555, 4'd2, 2'd1, 4'd13);
        expect_resp("sc_after_ld", 32'd0, 4'd2, 4'd13);
        step();
        load("ld7_final", 10'd7, 32'h55555555, 4'd1, 4'd14);

        // Backpressure: 10 cycles of loads with resp_ready low
        resp_ready = 1'b0;
        acc        = 0;
        for (int i = 0; i < 10; i++) begin
            req.wdata.meta_id = 4'(acc);
            req.wdata.core_id = 2'd0;
            req.wdata.amo     = 4'h0;
            req.wdata.data    = 32'h0;
            req.wen           = 1'b0;
            req.be            = 4'hF;
            req.tgt_addr      = {(acc == 0) ? 10'd5 : 10'd4, 4'h3};
            req.ini_addr      = 4'd8;
            req_valid         = 1'b1;
            #1;
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", acc, 32'd2);
        expect_resp("bp_head", 32'hDEADAAEF, 4'd8, 4'd0);
        resp_ready = 1'b1;
        step();
        expect_resp("bp_second", 32'h00000005, 4'd8, 4'd1);
        step();
        check("bp_drained", 32'(resp_valid), 32'd0);

        // Reset during AMO writeback
        do_req(mempool_pkg::AmoSwap, 1'b0, 4'hF, 10'd4, 32'hAAAAAAAA, 4'd1, 2'd0, 4'd9);
        rst = 1'b1;
        #1;
        check("rwb_mem_req", 32'(mem_req), 32'd0);
        check("rwb_mem_we", 32'(mem_we), 32'd0);
        check("rwb_resp_valid", 32'(resp_valid), 32'd0);
        step();
        check("rwb2_req_ready", 32'(req_ready), 32'd0);
        check("rwb2_resp_valid", 32'(resp_valid), 32'd0);
        check("rwb2_mem_req", 32'(mem_req), 32'd0);
        check("rwb2_mem_addr", 32'(mem_addr), 32'd0);
        check("rwb2_mem_wdata", mem_wdata, 32'd0);
        check("rwb2_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        load("ld4_post_rst", 10'd4, 32'h00000005, 4'd1, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
